ex_stage_bru: RTL and testbench

//  Parametrised EX-stage branch/jump resolution unit with an in-built dynamic predictor.
//  - Resolves branches and jumps from the bj info/data vectors.
//  - Compares the outcome with the IF-stage prediction and issues a registered redirect.
//  - Trains a 2-bit BHT and a direct-mapped BTB; keeps branch and mispredict counters.
//  - Sits between IF (prediction lookup) and EX (resolution).

---
 rtl/ex_stage_bru_pkg.sv | 28 ++
 rtl/ex_stage_bru_pred_table.sv | 72 +++++++
 rtl/ex_stage_bru.sv | 92 +++++++++
 tb/tb_ex_stage_bru.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_bru_pkg.sv
// Shared constants for the EX-stage branch resolution unit and its predictor tables.
package ex_stage_bru_pkg;

  // Default class-vector layout
  localparam int BJ_BUS      = 8;
  localparam int BJ_JALR_DEF = 0;

  // 2-bit BHT counter encodings
  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;

  // Why the EX stage is redirecting the front end
  typedef enum logic [1:0] {
    RD_NONE  = 2'd0,
    RD_DIR   = 2'd1,  // direction mispredicted
    RD_TGT   = 2'd2,  // taken as predicted, wrong target
    RD_ALIAS = 2'd3   // BTB hit on a non-branch instruction
  } rd_cause_e;

  // Saturating 2-bit counter step
  function automatic logic [1:0] bht_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == BHT_ST)  ? BHT_ST  : c + 2'd1;
    else       return (c == BHT_SNT) ? BHT_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/ex_stage_bru_pred_table.sv
// BHT + direct-mapped BTB storage: combinational lookup port, one update port.
module ex_stage_bru_pred_table
  import ex_stage_bru_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 64,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_taken,
  output logic [XLEN-1:0] lk_target,
  input  logic [XLEN-1:0] up_pc,
  input  logic            up_bht_en,
  input  logic            up_taken,
  input  logic            up_btb_wr,
  input  logic            up_btb_inv,
  input  logic [XLEN-1:0] up_target
);

  localparam int BHT_IW = $clog2(BHT_DEPTH);
  localparam int BTB_IW = $clog2(BTB_DEPTH);
  localparam int TAG_W  = XLEN - BTB_IW - 2;

  logic [1:0]           bht     [BHT_DEPTH];
  logic [BTB_DEPTH-1:0] btb_vld;
  logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
  logic [XLEN-1:0]      btb_tgt [BTB_DEPTH];

  logic [BHT_IW-1:0] lk_bi, up_bi;
  logic [BTB_IW-1:0] lk_ti, up_ti;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              lk_hit;
  logic              unused_pc_lsbs;

  // Instructions are word aligned, so pc[1:0] never indexes or tags
  assign unused_pc_lsbs = ^{lk_pc[1:0], up_pc[1:0]};

  assign lk_bi  = lk_pc[BHT_IW+1:2];
  assign up_bi  = up_pc[BHT_IW+1:2];
  assign lk_ti  = lk_pc[BTB_IW+1:2];
  assign up_ti  = up_pc[BTB_IW+1:2];
  assign lk_tag = lk_pc[XLEN-1:BTB_IW+2];
  assign up_tag = up_pc[XLEN-1:BTB_IW+2];

  // Lookup reads registered state only, so a same-cycle update is not visible
  always_comb begin
    lk_hit    = btb_vld[lk_ti] & (btb_tag[lk_ti] == lk_tag);
    lk_taken  = lk_hit & bht[lk_bi][1];
    lk_target = lk_hit ? btb_tgt[lk_ti] : '0;
  end

  // BHT counters train on every resolved branch/jump
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= BHT_WNT;
    else if (up_bht_en) bht[up_bi] <= bht_next(bht[up_bi], up_taken);

  // BTB valid bits: set on taken install, cleared on alias false-hit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)          btb_vld <= '0;
    else if (up_btb_wr)  btb_vld[up_ti] <= 1'b1;
    else if (up_btb_inv) btb_vld[up_ti] <= 1'b0;

  // BTB payload needs no reset; it is qualified by the valid bit
  always_ff @(posedge clk)
    if (up_btb_wr) begin
      btb_tag[up_ti] <= up_tag;
      btb_tgt[up_ti] <= up_target;
    end

endmodule

// File: rtl/ex_stage_bru.sv
// EX-stage branch/jump resolution: outcome vs prediction, registered redirect,
// predictor training and performance counters.
module ex_stage_bru
  import ex_stage_bru_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BJ_W      = BJ_BUS,
  parameter int BJ_JALR   = BJ_JALR_DEF,
  parameter int BHT_DEPTH = 64,
  parameter int BTB_DEPTH = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic [XLEN-1:0]  if_pred_target,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [BJ_W-1:0]  ex_bj_info,
  input  logic [BJ_W-1:0]  ex_bj_data,
  input  logic [XLEN-1:0]  ex_jmp_imm,
  input  logic [XLEN-1:0]  ex_op1,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  logic            is_bj, taken, act, mispred;
  logic [XLEN-1:0] sum, target, next_pc;
  rd_cause_e       cause;

  // Resolve the instruction and classify any mispredict; the shadow cycle
  // behind a redirect is a wrong-path slot and is ignored entirely
  always_comb begin
    is_bj   = |ex_bj_info;
    taken   = |(ex_bj_info & ex_bj_data);
    sum     = ex_jmp_imm + (ex_bj_info[BJ_JALR] ? ex_op1 : ex_pc);
    target  = sum & ~XLEN'(1);
    next_pc = taken ? target : ex_pc + XLEN'(4);
    act     = ex_valid & ~redirect_valid;
    cause   = RD_NONE;
    if (act) begin
      if (~is_bj & ex_pred_taken)                    cause = RD_ALIAS;
      else if (ex_pred_taken != taken)               cause = RD_DIR;
      else if (taken & (ex_pred_target != target))   cause = RD_TGT;
    end
    mispred = (cause != RD_NONE);
  end

  // Redirect pulses the cycle after a mispredict; the PC holds otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispred;
      if (mispred) redirect_pc <= next_pc;
    end

  // Performance counters, free-running and wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      br_cnt  <= br_cnt  + CNT_W'(act & is_bj);
      mis_cnt <= mis_cnt + CNT_W'(mispred);
    end

  ex_stage_bru_pred_table #(
    .XLEN      (XLEN),
    .BHT_DEPTH (BHT_DEPTH),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_tbl (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_pc      (if_pc),
    .lk_taken   (if_pred_taken),
    .lk_target  (if_pred_target),
    .up_pc      (ex_pc),
    .up_bht_en  (act & is_bj),
    .up_taken   (taken),
    .up_btb_wr  (act & is_bj & taken),
    .up_btb_inv (cause == RD_ALIAS),
    .up_target  (target)
  );

endmodule

// File: tb/tb_ex_stage_bru.sv
// Bench for ex_stage_bru: directed cases with literal expectations plus random
// traffic, all checked every cycle against a behavioural model.
module tb_ex_stage_bru;

  localparam int XLEN = 64, BJ_W = 8, BHT_D = 64, BTB_D = 16, CNT_W = 32;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic [XLEN-1:0]  if_pc, if_pred_target, ex_pc, ex_jmp_imm, ex_op1, ex_pred_target, redirect_pc;
  logic             if_pred_taken, ex_valid, ex_pred_taken, redirect_valid;
  logic [BJ_W-1:0]  ex_bj_info, ex_bj_data;
  logic [CNT_W-1:0] br_cnt, mis_cnt;

  int nchk = 0, nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_stage_bru #(.XLEN(XLEN), .BJ_W(BJ_W), .BJ_JALR(0), .BHT_DEPTH(BHT_D),
                 .BTB_DEPTH(BTB_D), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_bj_info(ex_bj_info), .ex_bj_data(ex_bj_data), .ex_jmp_imm(ex_jmp_imm),
    .ex_op1(ex_op1), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt));

  // ---------------- behavioural model ----------------
  int          m_bht  [BHT_D];   // counter strength 0..3, taken when >= 2
  bit          m_bv   [BTB_D];
  logic [63:0] m_bpc  [BTB_D];   // pc that installed the entry (tag = pc >> 6)
  logic [63:0] m_btgt [BTB_D];
  bit          m_rv;
  logic [63:0] m_rpc;
  logic [31:0] m_br, m_mis;

  bit          m_act, m_isbj, m_tk, m_mp;
  logic [63:0] m_tgt, m_nxt;

  function automatic int bhi(input logic [63:0] pc); return int'((pc >> 2) % BHT_D); endfunction
  function automatic int bti(input logic [63:0] pc); return int'((pc >> 2) % BTB_D); endfunction

  // {pred_taken, pred_target} for a fetch PC
  function automatic logic [64:0] m_lookup(input logic [63:0] pc);
    bit hit;
    hit = m_bv[bti(pc)] && ((m_bpc[bti(pc)] >> 6) == (pc >> 6));
    return {hit && (m_bht[bhi(pc)] >= 2), hit ? m_btgt[bti(pc)] : 64'h0};
  endfunction

  always_comb begin
    m_act  = ex_valid && !m_rv;
    m_isbj = (ex_bj_info != 0);
    m_tk   = ((ex_bj_info & ex_bj_data) != 0);
    m_tgt  = (ex_jmp_imm + (ex_bj_info[0] ? ex_op1 : ex_pc)) & ~64'h1;
    m_nxt  = m_tk ? m_tgt : ex_pc + 64'd4;
    m_mp   = m_act && ((ex_pred_taken != m_tk) || (m_tk && ex_pred_target != m_tgt));
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < BHT_D; i++) m_bht[i] <= 1;
      for (int i = 0; i < BTB_D; i++) m_bv[i] <= 1'b0;
      m_rv <= 1'b0; m_rpc <= '0; m_br <= '0; m_mis <= '0;
    end else begin
      m_rv <= m_mp;
      if (m_mp) begin m_rpc <= m_nxt; m_mis <= m_mis + 1; end
      if (m_act && m_isbj) begin
        m_br <= m_br + 1;
        m_bht[bhi(ex_pc)] <= m_tk ? ((m_bht[bhi(ex_pc)] < 3) ? m_bht[bhi(ex_pc)] + 1 : 3)
                                  : ((m_bht[bhi(ex_pc)] > 0) ? m_bht[bhi(ex_pc)] - 1 : 0);
      end
      if (m_act && m_isbj && m_tk) begin
        m_bv[bti(ex_pc)] <= 1'b1; m_bpc[bti(ex_pc)] <= ex_pc; m_btgt[bti(ex_pc)] <= m_tgt;
      end
      if (m_act && !m_isbj && ex_pred_taken) m_bv[bti(ex_pc)] <= 1'b0;
    end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Every cycle: compare all outputs against the model
  always @(negedge clk)
    if (chk_en && rst_n) begin
      chk("m.redirect_valid", 64'(redirect_valid), 64'(m_rv));
      chk("m.redirect_pc", redirect_pc, m_rpc);
      chk("m.br_cnt", 64'(br_cnt), 64'(m_br));
      chk("m.mis_cnt", 64'(mis_cnt), 64'(m_mis));
      chk("m.if_pred_taken", 64'(if_pred_taken), 64'(m_lookup(if_pc) >> 64));
      chk("m.if_pred_target", if_pred_target, m_lookup(if_pc) & {1'b0, {64{1'b1}}});
    end

  // ---------------- stimulus ----------------
  task automatic ex_drive(input bit v, input logic [63:0] pc, input logic [7:0] info, data,
                          input logic [63:0] imm, op1, input bit pt, input logic [63:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_bj_info = info; ex_bj_data = data;
    ex_jmp_imm = imm; ex_op1 = op1; ex_pred_taken = pt; ex_pred_target = ptgt;
    @(posedge clk); #2;
  endtask

  task automatic idle();
    ex_drive(1'b0, 64'h0, 8'h0, 8'h0, 64'h0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic look(input logic [63:0] pc);
    if_pc = pc; #1;
  endtask

  localparam logic [7:0] BEQ = 8'h02, JALR = 8'h01;

  initial begin
    if_pc = 64'h8000_0000; ex_valid = 0; ex_pc = 0; ex_bj_info = 0; ex_bj_data = 0;
    ex_jmp_imm = 0; ex_op1 = 0; ex_pred_taken = 0; ex_pred_target = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; chk_en = 1'b1;

    // 1: reset state
    idle(); look(64'h8000_0000);
    chk("rst.pred_taken", 64'(if_pred_taken), 64'h0);
    chk("rst.pred_target", if_pred_target, 64'h0);
    chk("rst.br_cnt", 64'(br_cnt), 64'h0);
    chk("rst.mis_cnt", 64'(mis_cnt), 64'h0);
    chk("rst.redirect_valid", 64'(redirect_valid), 64'h0);

    // 2: BEQ taken, predicted not-taken
    ex_drive(1, 64'h8000_0010, BEQ, BEQ, 64'h20, 64'h0, 0, 64'h0);
    chk("beq.redirect_valid", 64'(redirect_valid), 64'h1);
    chk("beq.redirect_pc", redirect_pc, 64'h8000_0030);
    chk("beq.mis_cnt", 64'(mis_cnt), 64'h1);
    look(64'h8000_0010);
    chk("beq.pred_taken", 64'(if_pred_taken), 64'h1);
    chk("beq.pred_target", if_pred_target, 64'h8000_0030);
    idle();

    // 3: three correctly predicted takens, then one not-taken (BHT 11 -> 10)
    repeat (3) begin
      ex_drive(1, 64'h8000_0010, BEQ, BEQ, 64'h20, 64'h0, 1, 64'h8000_0030);
      chk("sat.no_redirect", 64'(redirect_valid), 64'h0);
    end
    chk("sat.br_cnt", 64'(br_cnt), 64'd4);
    chk("sat.mis_cnt", 64'(mis_cnt), 64'd1);
    ex_drive(1, 64'h8000_0010, BEQ, 8'h00, 64'h20, 64'h0, 1, 64'h8000_0030);
    chk("nt.redirect_pc", redirect_pc, 64'h8000_0014);
    chk("nt.mis_cnt", 64'(mis_cnt), 64'd2);
    look(64'h8000_0010);
    chk("nt.still_taken", 64'(if_pred_taken), 64'h1);
    idle();

    // 4: JALR with odd sum, then a valid branch in the shadow cycle
    ex_drive(1, 64'h8000_0020, JALR, JALR, 64'h4, 64'h8000_1003, 0, 64'h0);
    chk("jalr.redirect_valid", 64'(redirect_valid), 64'h1);
    chk("jalr.redirect_pc", redirect_pc, 64'h8000_1006);
    ex_drive(1, 64'h8000_0040, BEQ, BEQ, 64'h20, 64'h0, 0, 64'h0);
    chk("shadow.redirect_valid", 64'(redirect_valid), 64'h0);
    chk("shadow.redirect_pc", redirect_pc, 64'h8000_1006);
    chk("shadow.br_cnt", 64'(br_cnt), 64'd6);
    chk("shadow.mis_cnt", 64'(mis_cnt), 64'd3);
    look(64'h8000_0040);
    chk("shadow.no_train", 64'(if_pred_taken), 64'h0);

    // 5: non-branch predicted taken (alias on BTB index 4)
    ex_drive(1, 64'h8000_0050, 8'h00, 8'h00, 64'h0, 64'h0, 1, 64'h8000_0030);
    chk("alias.redirect_pc", redirect_pc, 64'h8000_0054);
    chk("alias.mis_cnt", 64'(mis_cnt), 64'd4);
    chk("alias.br_cnt", 64'(br_cnt), 64'd6);
    look(64'h8000_0010);
    chk("alias.invalidated", 64'(if_pred_taken), 64'h0);
    chk("alias.target0", if_pred_target, 64'h0);
    idle();

    // 6: reset while a redirect is pending
    ex_drive(1, 64'h8000_0010, BEQ, BEQ, 64'h20, 64'h0, 0, 64'h0);
    chk("rst6.pending", 64'(redirect_valid), 64'h1);
    rst_n = 1'b0; #1;
    chk("rst6.redirect_valid", 64'(redirect_valid), 64'h0);
    chk("rst6.br_cnt", 64'(br_cnt), 64'h0);
    chk("rst6.mis_cnt", 64'(mis_cnt), 64'h0);
    look(64'h8000_0010);
    chk("rst6.btb_cleared", 64'(if_pred_taken), 64'h0);
    idle();
    rst_n = 1'b1;

    // Random traffic over a small aliasing PC pool
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] pc, imm, op1, ptgt;
      logic [7:0]  info, r8;
      logic [64:0] p;
      bit          pt, v;
      int          k;
      if (c == 1500) begin rst_n = 1'b0; #1; rst_n = 1'b1; end
      pc  = 64'h8000_0000 + 64'(4 * $urandom_range(0, 63));
      k   = int'($urandom_range(0, 9));
      info = (k < 3) ? 8'h00 : (k == 3) ? JALR : (8'h01 << $urandom_range(1, 7));
      r8  = 8'($urandom);
      imm = {{56{r8[7]}}, r8};
      op1 = 64'h8000_0000 + 64'($urandom_range(0, 4095));
      p   = m_lookup(pc);
      if ($urandom_range(0, 9) < 7) begin pt = p[64]; ptgt = p[63:0]; end
      else begin pt = 1'($urandom); ptgt = 64'h8000_0000 + 64'($urandom_range(0, 255) & ~1); end
      v = ($urandom_range(0, 99) < 85);
      if_pc = 64'h8000_0000 + 64'(4 * $urandom_range(0, 63));
      ex_drive(v, pc, info, 8'($urandom), imm, op1, pt, ptgt);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
